sevenseg_scan_driver: RTL

// - Time-multiplexed driver for an N-digit common-anode 7-segment display.
// - Sits directly downstream of clock120hz: consumes its slow square wave (scan_clk) and steps one digit per rising edge.
// - Frame-coherent: snapshots value/blank/dp at the start of each scan frame, so digits never mix two values.

---
 rtl/sevenseg_pkg.sv | 13 +
 rtl/sevenseg_scan_driver_if.sv | 22 ++
 rtl/hex_to_sevenseg.sv | 10 +
 rtl/sevenseg_scan_driver.sv | 111 +++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared types and segment patterns for the 7-segment scan driver.
`timescale 1ns/1ps
package sevenseg_pkg;
    typedef logic [6:0] seg_t;

    // Active-high {g,f,e,d,c,b,a} patterns for hex digits 0..F
    localparam seg_t SEG_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam seg_t SEG_OFF_N = 7'h7F;
endpackage

// File: rtl/sevenseg_scan_driver_if.sv
// Display-side bundle of the scan driver: scan clock and digit data in, anode/segment drive out.
`timescale 1ns/1ps
interface sevenseg_scan_driver_if #(parameter int NUM_DIGITS = 8);
    logic                    scan_clk;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   blank;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   an_n;
    logic [6:0]              seg_n;
    logic                    dp_n;
    logic                    frame_start;

    modport master (
        output scan_clk, value, blank, dp,
        input  an_n, seg_n, dp_n, frame_start
    );

    modport slave (
        input  scan_clk, value, blank, dp,
        output an_n, seg_n, dp_n, frame_start
    );
endinterface

// File: rtl/hex_to_sevenseg.sv
// Combinational hex nibble to active-high segment pattern.
`timescale 1ns/1ps
module hex_to_sevenseg
    import sevenseg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output seg_t       o_seg
);
    assign o_seg = SEG_LUT[i_nibble];
endmodule

// File: rtl/sevenseg_scan_driver.sv
// Frame-coherent N-digit common-anode scan driver stepped by an asynchronous scan clock.
// Optional build macro: LEADING_ZERO_BLANK_EN (auto-blank leading zero digits).
`timescale 1ns/1ps
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic                   clk_in,
    input logic                   reset,
    sevenseg_scan_driver_if.slave bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = NUM_DIGITS'(1);

    logic [SYNC_STAGES-1:0]  r_sync;
    logic                    r_prev;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_value_q;
    logic [NUM_DIGITS-1:0]   r_blank_q;
    logic [NUM_DIGITS-1:0]   r_dp_q;
    logic [NUM_DIGITS-1:0]   r_an_n;
    seg_t                    r_seg_n;
    logic                    r_dp_n;
    logic                    r_frame_start;

    logic                    w_adv;
    logic                    w_wrap;
    logic [IDX_W-1:0]        w_next_idx;
    logic [4*NUM_DIGITS-1:0] w_val_src;
    logic [NUM_DIGITS-1:0]   w_blank_src;
    logic [NUM_DIGITS-1:0]   w_dp_src;
    logic [NUM_DIGITS-1:0]   w_lz;
    logic [3:0]              w_nibble;
    logic                    w_blanked;
    seg_t                    w_seg;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.scan_clk};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_adv      = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign w_wrap     = (r_idx == LAST_IDX);
    assign w_next_idx = w_wrap ? '0 : r_idx + 1'b1;

    // Digit 0 is driven from the live inputs, since the snapshot loads on that same edge
    assign w_val_src   = w_wrap ? bus.value : r_value_q;
    assign w_blank_src = w_wrap ? bus.blank : r_blank_q;
    assign w_dp_src    = w_wrap ? bus.dp    : r_dp_q;

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        logic v_seen;
        w_lz   = '0;
        v_seen = 1'b0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            v_seen   = v_seen | (|w_val_src[4*i +: 4]);
            w_lz[i]  = ~v_seen;
        end
    end
`else
    assign w_lz = '0;
`endif

    assign w_nibble  = w_val_src[{w_next_idx, 2'b00} +: 4];
    assign w_blanked = w_blank_src[w_next_idx] | w_lz[w_next_idx];

    hex_to_sevenseg u_dec (
        .i_nibble (w_nibble),
        .o_seg    (w_seg)
    );

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_idx         <= LAST_IDX;
            r_value_q     <= '0;
            r_blank_q     <= '0;
            r_dp_q        <= '0;
            r_an_n        <= '1;
            r_seg_n       <= SEG_OFF_N;
            r_dp_n        <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_adv & w_wrap;
            if (w_adv) begin
                r_idx <= w_next_idx;
                if (w_wrap) begin
                    r_value_q <= bus.value;
                    r_blank_q <= bus.blank;
                    r_dp_q    <= bus.dp;
                end
                r_an_n  <= w_blanked ? '1 : ~(ONE_HOT0 << w_next_idx);
                r_seg_n <= w_blanked ? SEG_OFF_N : ~w_seg;
                r_dp_n  <= w_blanked | ~w_dp_src[w_next_idx];
            end
        end
    end

    assign bus.an_n        = r_an_n;
    assign bus.seg_n       = r_seg_n;
    assign bus.dp_n        = r_dp_n;
    assign bus.frame_start = r_frame_start;
endmodule
